ysyx_24110015_wbu: RTL and testbench
====================================

# ysyx_24110015_wbu

Write-back unit of the multi-cycle core, directly downstream of the load/store unit. Accepts one retired instruction per handshake, captures AXI-lite load data when the read completes, and performs byte-lane selection and sign/zero extension. Commits the register-file write, the CSR writes and the next PC in a single one-cycle commit strobe.

## Interface
- No parameters.
- `clk  in  1`: core clock.
- `rst  in  1`: asynchronous reset, active-low. The stage is held in reset while `rst`=0.
- `in_valid  in  1`: the load/store stage presents an instruction.
- `in_ready  out  1`: the unit can accept an instruction; high only in IDLE.
- `alu_out_i  in  32`: ALU result; doubles as the load address.
- `pc_next_i  in  32`: next PC.
- `RegWrite_i  in  1`, `wb_addr_i  in  5`: GPR write enable and write address.
- `zicsr_i  in  1`, `csr_rdata_i  in  32`: CSR instruction flag and old CSR value.
- `din_{mstatus,mtvec,mepc,mcause}_i  in  32`: new CSR values.
- `wen_{mstatus,mtvec,mepc,mcause}_i  in  1`: CSR write enables.
- `func3_i  in  3`, `MemRead_i  in  1`: load type and load flag.
- `mem_rdata_i  in  32`: AXI rdata. It is word-lane aligned and valid only while `dmemR_end_i`=1.
- `dmemR_end_i  in  1`: AXI read completed (rvalid & rready).
- `rf_wen  out  1`, `rf_waddr  out  5`, `rf_wdata  out  32`: GPR write port.
- `csr_wen_{mstatus,mtvec,mepc,mcause}  out  1`, `csr_wdata_{…}  out  32`: CSR write ports.
- `pc_wen  out  1`, `pc_wdata  out  32`: PC update.
- `commit  out  1`: one-cycle retire strobe.
- `load_misalign  out  1`: misaligned-load pulse. Present only with the macro.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - WAIT_R: a load is pending.
  - COMMIT: exactly one cycle.
- IDLE, on `in_valid`:
  - Latch all `*_i` fields.
  - If `MemRead_i`=1 and `dmemR_end_i`=1 in the same cycle: also latch `mem_rdata_i` and go to COMMIT.
  - If `MemRead_i`=1 without `dmemR_end_i`: go to WAIT_R.
  - Otherwise: go to COMMIT.
- WAIT_R: on `dmemR_end_i`, latch `mem_rdata_i` and go to COMMIT. Otherwise hold.
- COMMIT: always go to IDLE.
- Ignored inputs:
  - `dmemR_end_i` in IDLE without an accepted load, and in COMMIT.
  - `in_valid` outside IDLE.
- Write-back data selection, in priority order:
  - latched load: extended load data;
  - `zicsr`: `csr_rdata`;
  - otherwise: `alu_out`.
- Load extension, with off = latched `alu_out[1:0]` and lane = rdata >> (8·off):
  - LB/LBU (`func3` 000/100): lane[7:0], sign-/zero-extended.
  - LH/LHU (001/101): (rdata >> 16·off[1])[15:0], sign-/zero-extended.
  - LW (010): rdata unshifted.
  - Other `func3` values with MemRead: treated as LW.
- COMMIT-cycle outputs (all zero in every other state):
  - `rf_wen` = RegWrite & (waddr≠0).
  - CSR `wen`s = latched enables.
  - `pc_wen`=1, `commit`=1.
- `rf_waddr`, `rf_wdata`, `csr_wdata_*` and `pc_wdata` come from the latched registers and the extender. They are stable from the cycle after accept until the next accept.

## Timing
- Reset values: state IDLE, all latched registers 0.
  - `in_ready`=1.
  - All strobes (`rf_wen`, CSR `wen`s, `pc_wen`, `commit`, `load_misalign`) 0.
  - All data outputs 0.
- Reset asserted mid-operation (WAIT_R or COMMIT): return to IDLE immediately. No commit is emitted and the pending load is dropped.
- Latency, non-load: accept at cycle t, commit at t+1.
- Latency, load: `dmemR_end_i` at t+k (k≥0), commit at t+k+1.
- Throughput: accept to next accept is ≥2 cycles.
- All strobes are decoded combinationally from the state register and have no other combinational input paths.

## Configuration
- `YSYX_24110015_WBU_MISALIGN_EN`, when defined:
  - A load with LH/LHU and off[0]=1, or LW and off≠0, pulses `load_misalign` in COMMIT and forces `rf_wen`=0.
  - `pc_wen` and `commit` still assert.
- When not defined:
  - The port is absent.
  - Misaligned offsets are handled by truncation as above (LH uses off[1] only; LW ignores off).
  - `rf_wen` is unaffected.

## Structure
- Package `ysyx_24110015_pkg` holds:
  - the state enum (IDLE, WAIT_R, COMMIT);
  - `func3` load constants (LB, LH, LW, LBU, LHU).
- Sub-module `ysyx_24110015_load_ext`: combinational extender taking `func3`, off and rdata, producing data (and the misaligned flag when the macro is defined).

## Test plan
1. LW at `alu_out`=0x80000004, `wb_addr`=5. `dmemR_end_i` two cycles after accept with rdata 0xDEADBEEF → one cycle later `rf_wen`=1, waddr 5, wdata 0xDEADBEEF, `commit`=1.
2. LB at off 3, rdata 0x80123456, end in the accept cycle → commit next cycle with wdata 0xFFFFFF80. LBU with the same stimulus → 0x00000080.
3. LH at off 2, rdata 0x80011234 → 0xFFFF8001. LHU with the same stimulus → 0x00008001.
4. CSR op: `zicsr`=1, `csr_rdata`=0x1800, `wen_mepc`=1, `din_mepc`=0x80000010, `pc_next`=0x80000020 → commit at t+1 with:
   - rf wdata 0x1800;
   - `csr_wen_mepc` high for one cycle with wdata 0x80000010;
   - `pc_wdata` 0x80000020.
5. Boundary cases:
   - ALU op with `RegWrite`=1, `wb_addr`=0 → `rf_wen`=0, `commit`=1.
   - `rst` driven low in WAIT_R, then a late `dmemR_end_i` after release → no commit, `in_ready`=1.
6. LW at off 1, rdata 0x11223344:
   - with the macro → `load_misalign`=1, `rf_wen`=0, `commit`=1;
   - without the macro → `rf_wen`=1, wdata 0x11223344.

Source files
------------

// File: rtl/ysyx_24110015_pkg.sv
// ysyx_24110015_pkg: shared types for the write-back unit
// Holds the write-back FSM state enum and the func3 load-type encodings.
package ysyx_24110015_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_R,
        COMMIT
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_24110015_load_ext.sv
// ysyx_24110015_load_ext: byte-lane selection and sign/zero extension of load data
// Ports: func3 (load type), off (address low bits), rdata (word-aligned bus data),
//        data (extended result), misalign (only with YSYX_24110015_WBU_MISALIGN_EN).
// Unknown func3 values fall through to a full-word load.
module ysyx_24110015_load_ext
    import ysyx_24110015_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
`ifdef YSYX_24110015_WBU_MISALIGN_EN
    ,
    output logic        misalign
`endif
);

    logic [31:0] lane;
    logic [15:0] half;
    logic        is_byte;
    logic        is_half;

    assign lane    = rdata >> {off, 3'b000};
    assign half    = off[1] ? rdata[31:16] : rdata[15:0];
    assign is_byte = (func3 == LB) || (func3 == LBU);
    assign is_half = (func3 == LH) || (func3 == LHU);

    always_comb begin
        data = rdata;
        case (func3)
            LB:      data = {{24{lane[7]}}, lane[7:0]};
            LBU:     data = {24'b0, lane[7:0]};
            LH:      data = {{16{half[15]}}, half};
            LHU:     data = {16'b0, half};
            default: data = rdata;
        endcase
    end

`ifdef YSYX_24110015_WBU_MISALIGN_EN
    // Anything decoded as a word load must be 4-byte aligned.
    assign misalign = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
`endif

endmodule

// File: rtl/ysyx_24110015_wbu.sv
// ysyx_24110015_wbu: write-back unit, retires one instruction per handshake
// Ports: clk, rst (async, active-low); in_valid/in_ready handshake; *_i instruction
//        fields from the load/store stage; mem_rdata_i/dmemR_end_i AXI read return;
//        rf_*, csr_*, pc_* write ports and the one-cycle commit strobe.
// Optional: YSYX_24110015_WBU_MISALIGN_EN adds load_misalign and suppresses rf_wen
//           on misaligned halfword/word loads.
module ysyx_24110015_wbu
    import ysyx_24110015_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] pc_next_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  wb_addr_i,
    input  logic        zicsr_i,
    input  logic [31:0] csr_rdata_i,
    input  logic [31:0] din_mstatus_i,
    input  logic [31:0] din_mtvec_i,
    input  logic [31:0] din_mepc_i,
    input  logic [31:0] din_mcause_i,
    input  logic        wen_mstatus_i,
    input  logic        wen_mtvec_i,
    input  logic        wen_mepc_i,
    input  logic        wen_mcause_i,
    input  logic [2:0]  func3_i,
    input  logic        MemRead_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        dmemR_end_i,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        csr_wen_mstatus,
    output logic        csr_wen_mtvec,
    output logic        csr_wen_mepc,
    output logic        csr_wen_mcause,
    output logic [31:0] csr_wdata_mstatus,
    output logic [31:0] csr_wdata_mtvec,
    output logic [31:0] csr_wdata_mepc,
    output logic [31:0] csr_wdata_mcause,
    output logic        pc_wen,
    output logic [31:0] pc_wdata,
    output logic        commit
`ifdef YSYX_24110015_WBU_MISALIGN_EN
    ,
    output logic        load_misalign
`endif
);

    state_t      state, state_nx;
    logic        accept;
    logic [31:0] alu_q, pc_q, csr_rdata_q, rdata_q, ld_data;
    logic [31:0] din_mstatus_q, din_mtvec_q, din_mepc_q, din_mcause_q;
    logic [3:0]  cwen_q;
    logic [2:0]  func3_q;
    logic [4:0]  waddr_q;
    logic        regwrite_q, zicsr_q, memread_q, in_commit, mis;

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q         <= '0;
            pc_q          <= '0;
            csr_rdata_q   <= '0;
            rdata_q       <= '0;
            din_mstatus_q <= '0;
            din_mtvec_q   <= '0;
            din_mepc_q    <= '0;
            din_mcause_q  <= '0;
            cwen_q        <= '0;
            func3_q       <= '0;
            waddr_q       <= '0;
            regwrite_q    <= 1'b0;
            zicsr_q       <= 1'b0;
            memread_q     <= 1'b0;
        end else begin
            if (accept) begin
                alu_q         <= alu_out_i;
                pc_q          <= pc_next_i;
                csr_rdata_q   <= csr_rdata_i;
                din_mstatus_q <= din_mstatus_i;
                din_mtvec_q   <= din_mtvec_i;
                din_mepc_q    <= din_mepc_i;
                din_mcause_q  <= din_mcause_i;
                cwen_q        <= {wen_mstatus_i, wen_mtvec_i, wen_mepc_i, wen_mcause_i};
                func3_q       <= func3_i;
                waddr_q       <= wb_addr_i;
                regwrite_q    <= RegWrite_i;
                zicsr_q       <= zicsr_i;
                memread_q     <= MemRead_i;
            end
            // Read data is captured only when a load is being accepted or is pending.
            if (dmemR_end_i && ((accept && MemRead_i) || (state == WAIT_R)))
                rdata_q <= mem_rdata_i;
        end
    end

    ysyx_24110015_load_ext u_load_ext (
        .func3    (func3_q),
        .off      (alu_q[1:0]),
        .rdata    (rdata_q),
        .data     (ld_data)
`ifdef YSYX_24110015_WBU_MISALIGN_EN
        ,
        .misalign (mis)
`endif
    );

`ifdef YSYX_24110015_WBU_MISALIGN_EN
    assign load_misalign = in_commit && memread_q && mis;
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        in_commit = 1'b0;
        state_nx  = (state == IDLE)   ? (in_valid ? ((MemRead_i && !dmemR_end_i) ? WAIT_R : COMMIT) : IDLE) :
                    (state == WAIT_R) ? (dmemR_end_i ? COMMIT : WAIT_R) : IDLE;
        in_ready  = (state == IDLE);
        in_commit = (state == COMMIT);
    end

    assign commit          = in_commit;
    assign pc_wen          = in_commit;
    assign rf_wen          = in_commit && regwrite_q && (waddr_q != 5'd0) && !(memread_q && mis);
    assign csr_wen_mstatus = in_commit && cwen_q[3];
    assign csr_wen_mtvec   = in_commit && cwen_q[2];
    assign csr_wen_mepc    = in_commit && cwen_q[1];
    assign csr_wen_mcause  = in_commit && cwen_q[0];

    assign rf_waddr          = waddr_q;
    assign rf_wdata          = memread_q ? ld_data : zicsr_q ? csr_rdata_q : alu_q;
    assign pc_wdata          = pc_q;
    assign csr_wdata_mstatus = din_mstatus_q;
    assign csr_wdata_mtvec   = din_mtvec_q;
    assign csr_wdata_mepc    = din_mepc_q;
    assign csr_wdata_mcause  = din_mcause_q;

endmodule

// File: tb/tb_ysyx_24110015_wbu.sv
// tb_ysyx_24110015_wbu: vector table plus scoreboard bench for the write-back unit
module tb_ysyx_24110015_wbu;
    import ysyx_24110015_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid, in_ready;
    logic [31:0] alu_out_i, pc_next_i, csr_rdata_i, mem_rdata_i;
    logic [31:0] din_mstatus_i, din_mtvec_i, din_mepc_i, din_mcause_i;
    logic        wen_mstatus_i, wen_mtvec_i, wen_mepc_i, wen_mcause_i;
    logic        RegWrite_i, zicsr_i, MemRead_i, dmemR_end_i;
    logic [4:0]  wb_addr_i;
    logic [2:0]  func3_i;
    logic        rf_wen, pc_wen, commit;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pc_wdata;
    logic        csr_wen_mstatus, csr_wen_mtvec, csr_wen_mepc, csr_wen_mcause;
    logic [31:0] csr_wdata_mstatus, csr_wdata_mtvec, csr_wdata_mepc, csr_wdata_mcause;
`ifdef YSYX_24110015_WBU_MISALIGN_EN
    logic        load_misalign;
`endif

    ysyx_24110015_wbu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out_i(alu_out_i), .pc_next_i(pc_next_i), .RegWrite_i(RegWrite_i),
        .wb_addr_i(wb_addr_i), .zicsr_i(zicsr_i), .csr_rdata_i(csr_rdata_i),
        .din_mstatus_i(din_mstatus_i), .din_mtvec_i(din_mtvec_i),
        .din_mepc_i(din_mepc_i), .din_mcause_i(din_mcause_i),
        .wen_mstatus_i(wen_mstatus_i), .wen_mtvec_i(wen_mtvec_i),
        .wen_mepc_i(wen_mepc_i), .wen_mcause_i(wen_mcause_i),
        .func3_i(func3_i), .MemRead_i(MemRead_i), .mem_rdata_i(mem_rdata_i),
        .dmemR_end_i(dmemR_end_i), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .csr_wen_mstatus(csr_wen_mstatus),
        .csr_wen_mtvec(csr_wen_mtvec), .csr_wen_mepc(csr_wen_mepc),
        .csr_wen_mcause(csr_wen_mcause), .csr_wdata_mstatus(csr_wdata_mstatus),
        .csr_wdata_mtvec(csr_wdata_mtvec), .csr_wdata_mepc(csr_wdata_mepc),
        .csr_wdata_mcause(csr_wdata_mcause), .pc_wen(pc_wen), .pc_wdata(pc_wdata),
        .commit(commit)
`ifdef YSYX_24110015_WBU_MISALIGN_EN
        , .load_misalign(load_misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [2:0]  f3;
        logic        mem;
        logic [31:0] rdata;
        int          dly;
        logic        rw;
        logic [4:0]  wa;
        logic        zicsr;
        logic [31:0] csr_rd;
        logic [31:0] pc;
        logic [3:0]  cwen;
        logic [31:0] din;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic        mis;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [3:0]  cwen;
        logic [31:0] din;
        logic        mis;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vt[14];
    int   n_vec = 0, n_err = 0, cyc = 0, n_commit = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every commit pops the oldest expected retirement.
    always @(negedge clk) begin
        if (rst) begin
            if (commit) begin
                n_commit++;
                if (sb.size() == 0)
                    chk("unexpected_commit", 32'(commit), 32'd0);
                else begin
                    e = sb.pop_front();
`ifdef YSYX_24110015_WBU_MISALIGN_EN
                    chk("rf_wen", 32'(rf_wen), 32'(e.wen & ~e.mis));
                    chk("load_misalign", 32'(load_misalign), 32'(e.mis));
`else
                    chk("rf_wen", 32'(rf_wen), 32'(e.wen));
`endif
                    chk("latency", cyc, e.due);
                    chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
                    chk("rf_wdata", rf_wdata, e.wd);
                    chk("pc_wen", 32'(pc_wen), 32'd1);
                    chk("pc_wdata", pc_wdata, e.pc);
                    chk("in_ready_commit", 32'(in_ready), 32'd0);
                    chk("csr_wen", 32'({csr_wen_mstatus, csr_wen_mtvec, csr_wen_mepc, csr_wen_mcause}), 32'(e.cwen));
                    chk("csr_wdata_mstatus", csr_wdata_mstatus, e.din ^ 32'h1);
                    chk("csr_wdata_mtvec", csr_wdata_mtvec, e.din ^ 32'h2);
                    chk("csr_wdata_mepc", csr_wdata_mepc, e.din);
                    chk("csr_wdata_mcause", csr_wdata_mcause, e.din ^ 32'h3);
                end
            end else
                chk("idle_strobes", 32'({rf_wen, pc_wen, csr_wen_mstatus, csr_wen_mtvec, csr_wen_mepc, csr_wen_mcause}), 32'd0);
        end
    end

    task automatic scramble();
        alu_out_i = 32'h5A5A5A5A; pc_next_i = 32'hA5A5A5A5; csr_rdata_i = 32'h3C3C3C3C;
        mem_rdata_i = 32'h0BADF00D; func3_i = 3'b110; wb_addr_i = 5'd30;
        RegWrite_i = 1'b0; zicsr_i = 1'b1; MemRead_i = 1'b0; dmemR_end_i = 1'b0; in_valid = 1'b0;
        din_mstatus_i = 32'h0; din_mtvec_i = 32'h0; din_mepc_i = 32'h0; din_mcause_i = 32'h0;
        {wen_mstatus_i, wen_mtvec_i, wen_mepc_i, wen_mcause_i} = 4'b0;
    endtask

    task automatic apply(vec_t v);
        exp_t x;
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        alu_out_i = v.alu; func3_i = v.f3; MemRead_i = v.mem; RegWrite_i = v.rw;
        wb_addr_i = v.wa; zicsr_i = v.zicsr; csr_rdata_i = v.csr_rd; pc_next_i = v.pc;
        {wen_mstatus_i, wen_mtvec_i, wen_mepc_i, wen_mcause_i} = v.cwen;
        din_mstatus_i = v.din ^ 32'h1; din_mtvec_i = v.din ^ 32'h2;
        din_mepc_i = v.din; din_mcause_i = v.din ^ 32'h3;
        dmemR_end_i = v.mem && (v.dly == 0);
        mem_rdata_i = (v.mem && v.dly == 0) ? v.rdata : 32'h0BADF00D;
        in_valid = 1'b1;
        x = '{v.exp_wen, v.wa, v.exp_wdata, v.pc, v.cwen, v.din, v.mis,
              cyc + 1 + (v.mem ? v.dly : 0)};
        sb.push_back(x);
        @(negedge clk);
        scramble();
        if (v.mem && v.dly > 0) begin
            repeat (v.dly - 1) @(negedge clk);
            dmemR_end_i = 1'b1; mem_rdata_i = v.rdata;
            @(negedge clk);
            dmemR_end_i = 1'b0; mem_rdata_i = 32'h0BADF00D;
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk("commit_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int c0;
        vt[0]  = '{32'h80000004, LW,  1'b1, 32'hDEADBEEF, 2, 1'b1, 5'd5,  1'b0, 32'h0,   32'h80000008, 4'b0000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vt[1]  = '{32'h80000003, LB,  1'b1, 32'h80123456, 0, 1'b1, 5'd6,  1'b0, 32'h0,   32'h00001004, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
        vt[2]  = '{32'h80000003, LBU, 1'b1, 32'h80123456, 0, 1'b1, 5'd6,  1'b0, 32'h0,   32'h00001008, 4'b0000, 32'h0,        1'b1, 32'h00000080, 1'b0};
        vt[3]  = '{32'h80000002, LH,  1'b1, 32'h80011234, 0, 1'b1, 5'd7,  1'b0, 32'h0,   32'h0000100C, 4'b0000, 32'h0,        1'b1, 32'hFFFF8001, 1'b0};
        vt[4]  = '{32'h80000002, LHU, 1'b1, 32'h80011234, 0, 1'b1, 5'd7,  1'b0, 32'h0,   32'h00001010, 4'b0000, 32'h0,        1'b1, 32'h00008001, 1'b0};
        vt[5]  = '{32'h00001234, LB,  1'b0, 32'h0,        0, 1'b1, 5'd10, 1'b1, 32'h1800, 32'h80000020, 4'b0010, 32'h80000010, 1'b1, 32'h00001800, 1'b0};
        vt[6]  = '{32'h00000055, LB,  1'b0, 32'h0,        0, 1'b1, 5'd0,  1'b0, 32'h0,   32'h00000058, 4'b0000, 32'h0,        1'b0, 32'h00000055, 1'b0};
        vt[7]  = '{32'h80000001, LW,  1'b1, 32'h11223344, 1, 1'b1, 5'd7,  1'b0, 32'h0,   32'h00000200, 4'b0000, 32'h0,        1'b1, 32'h11223344, 1'b1};
        vt[8]  = '{32'h80000000, LB,  1'b1, 32'h000000F7, 3, 1'b1, 5'd8,  1'b0, 32'h0,   32'h00000204, 4'b0000, 32'h0,        1'b1, 32'hFFFFFFF7, 1'b0};
        vt[9]  = '{32'h80000000, LHU, 1'b1, 32'hABCD7FFF, 1, 1'b1, 5'd9,  1'b0, 32'h0,   32'h00000208, 4'b0000, 32'h0,        1'b1, 32'h00007FFF, 1'b0};
        vt[10] = '{32'h80000001, LH,  1'b1, 32'h80011234, 0, 1'b1, 5'd11, 1'b0, 32'h0,   32'h0000020C, 4'b0000, 32'h0,        1'b1, 32'h00001234, 1'b1};
        vt[11] = '{32'h80000000, 3'b011, 1'b1, 32'hCAFEF00D, 1, 1'b1, 5'd12, 1'b1, 32'h999, 32'h00000210, 4'b0000, 32'h0,     1'b1, 32'hCAFEF00D, 1'b0};
        vt[12] = '{32'h0000CAFE, LW,  1'b0, 32'h0,        0, 1'b0, 5'd3,  1'b0, 32'h0,   32'h00000300, 4'b1111, 32'hA5A50000, 1'b0, 32'h0000CAFE, 1'b0};
        vt[13] = '{32'h80000003, LBU, 1'b1, 32'h7F000000, 0, 1'b1, 5'd31, 1'b0, 32'h0,   32'h00000304, 4'b0000, 32'h0,        1'b1, 32'h0000007F, 1'b0};

        scramble();
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_strobes", 32'({rf_wen, pc_wen, commit, csr_wen_mstatus, csr_wen_mtvec, csr_wen_mepc, csr_wen_mcause}), 32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_pc_wdata", pc_wdata, 32'd0);
        chk("reset_csr_wdata", csr_wdata_mstatus | csr_wdata_mtvec | csr_wdata_mepc | csr_wdata_mcause, 32'd0);
`ifdef YSYX_24110015_WBU_MISALIGN_EN
        chk("reset_load_misalign", 32'(load_misalign), 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) apply(vt[i]);

        // Reset while a load is pending: the load is dropped and a late read return is ignored.
        c0 = n_commit;
        alu_out_i = 32'h80000000; func3_i = LW; MemRead_i = 1'b1; RegWrite_i = 1'b1;
        wb_addr_i = 5'd4; zicsr_i = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        scramble();
        @(negedge clk);
        chk("wait_r_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_commit", 32'(commit), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmemR_end_i = 1'b1; mem_rdata_i = 32'h12345678;
        @(negedge clk);
        dmemR_end_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_end_no_commit", n_commit, c0);
        chk("late_end_in_ready", 32'(in_ready), 32'd1);

        // Unit must still work normally afterwards.
        apply(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
